// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared encodings for the IF/DM unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Owner of the transaction currently in flight
    localparam logic OWN_IF = 1'b1;
    localparam logic OWN_DM = 1'b0;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_starve
// Description : Saturating count of DM grants taken while IF was waiting.
//               Raises o_force_if once the count reaches STARVE_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_grant_dm,
    input  logic i_grant_if,
    output logic o_force_if
);

    localparam int              c_cnt_w   = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STARVE_MAX);

    logic [c_cnt_w-1:0] r_cnt;

    // Count DM wins against a waiting IF; any IF win or an IF-free IDLE clears
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_grant_if) begin
            r_cnt <= '0;
        end else if (i_grant_dm && i_if_req) begin
            if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end else if (i_idle && !i_if_req) begin
            r_cnt <= '0;
        end
    end

    assign o_force_if = (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported memory between the instruction
//               fetch port and the load/store port, one transaction at a
//               time, with stall outputs for the waiting pipeline ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    // load/store port
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_valid,
    output logic            dm_stall,
    // memory side
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    state_t r_state;
    logic   r_owner;

    logic   w_idle;
    logic   w_force_if;
    logic   w_grant_dm;
    logic   w_grant_if;
    logic   w_ack;

    // DM has priority unless IF has been passed over too many times
    assign w_idle     = (r_state == IDLE);
    assign w_grant_dm = w_idle & dm_req & (~if_req | ~w_force_if);
    assign w_grant_if = w_idle & if_req & ~w_grant_dm;

    mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_idle     (w_idle),
        .i_if_req   (if_req),
        .i_grant_dm (w_grant_dm),
        .i_grant_if (w_grant_if),
        .o_force_if (w_force_if)
    );

    // Completion is only honoured in RESP and never while reset is asserted,
    // so an abandoned transaction can not produce a late valid pulse.
    assign w_ack    = rst & (r_state == RESP) & mem_rvalid;
    assign if_valid = w_ack & (r_owner == OWN_IF);
    assign dm_valid = w_ack & (r_owner == OWN_DM);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = dm_valid ? mem_rdata : '0;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    // Sequencer: latch winner in IDLE, hold request until grant, await ack
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_DM;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_dm || w_grant_if) begin
                        r_state   <= REQ;
                        mem_req   <= 1'b1;
                        r_owner   <= w_grant_if ? OWN_IF : OWN_DM;
                        mem_we    <= w_grant_if ? 1'b0 : dm_we;
                        mem_be    <= w_grant_if ? '1 : dm_be;
                        mem_addr  <= w_grant_if ? if_addr : dm_addr;
                        mem_wdata <= w_grant_if ? '0 : dm_wdata;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        r_state <= RESP;
                        mem_req <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch (IF) port and its load/store (DM) port. Sits between the pipelined core and the memory. Sequences one memory transaction at a time through a request/grant/response handshake. Generates per-port stall signals so the pipeline freezes while its access is outstanding.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive DM grants allowed while IF waits (≥1)
- `clk` in 1, single clock, rising edge
- `rst` in 1, synchronous, active-low reset
- `if_req` in 1, fetch request; held until `if_valid`
- `if_addr` in AW, fetch address
- `if_rdata` out DW, fetched instruction; valid when `if_valid`
- `if_valid` out 1, one-cycle fetch completion pulse
- `if_stall` out 1, `if_req & ~if_valid`
- `dm_req` in 1, load/store request; held until `dm_valid`
- `dm_we` in 1, 1 = store
- `dm_be` in DW/8, byte enables for stores
- `dm_addr` in AW, data address
- `dm_wdata` in DW, store data
- `dm_rdata` out DW, load data; valid when `dm_valid`
- `dm_valid` out 1, one-cycle load/store completion pulse
- `dm_stall` out 1, `dm_req & ~dm_valid`
- `mem_req` out 1, memory request (registered)
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` out 1/DW/8/AW/DW, latched request fields (registered)
- `mem_gnt` in 1, memory accepts request this cycle
- `mem_rvalid` in 1, response/ack (loads, fetches and stores all ack)
- `mem_rdata` in DW, response data

## Operation
- FSM states: IDLE, REQ, RESP. Owner register: IF or DM.
- IDLE: if any request, choose owner, latch its fields into `mem_*` regs, go to REQ. Otherwise stay in IDLE.
- Arbitration in IDLE:
  - Only one port requesting → that port wins.
  - Both requesting → DM wins, unless `starve_cnt == STARVE_MAX`, in which case IF wins.
- `starve_cnt`:
  - Increments on each DM grant while `if_req` = 1.
  - Clears on an IF grant, or when `if_req` = 0 in IDLE.
  - Saturates at STARVE_MAX.
- IF latches: `mem_we` = 0, `mem_be` = all ones, `mem_wdata` = 0.
- REQ: `mem_req` = 1. Fields stay stable until `mem_gnt`. On `mem_gnt`, go to RESP.
- RESP: `mem_req` = 0. On `mem_rvalid`:
  - Owner's `*_valid` = 1 (combinational, same cycle).
  - Owner's `*_rdata` = `mem_rdata` (passthrough).
  - Next state is IDLE.
- Non-owner `*_valid` = 0 always. Non-owner `*_rdata` = 0.
- Requests are re-sampled only in IDLE. A requester must drop `*_req` the cycle after its `*_valid`, or it is served again.
- `mem_rvalid` outside RESP is ignored. `mem_gnt` outside REQ is ignored.
- Reset (`rst` = 0 at a clock edge), including mid-transaction:
  - State → IDLE; owner → DM; `starve_cnt` → 0.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` → 0.
  - In-flight transaction is abandoned; no `*_valid` pulses for it.
- Reset values: `if_valid`, `dm_valid`, `if_rdata`, `dm_rdata` = 0. `if_stall`/`dm_stall` follow their `*_req` inputs.

## Timing
- Minimum latency is 2 cycles from request to valid:
  - Cycle 0: IDLE samples the request.
  - Cycle 1: REQ, with `mem_gnt` = 1.
  - Cycle 2: RESP, with `mem_rvalid` = 1, so `*_valid` = 1.
- Each extra cycle without `mem_gnt` or `mem_rvalid` adds one cycle.
- Throughput: one transaction per 3 cycles minimum, because IDLE occurs between transactions.
- A second requester that asserts during a transaction waits in stall until the next IDLE.
- Simultaneous `mem_gnt` and reset: reset wins.

## Structure
- Shared package/header `mem_arb_pkg`:
  - FSM state encodings (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2).
  - Owner encoding (OWN_IF = 1'b1, OWN_DM = 1'b0).
- One sub-module is natural: `mem_arb_starve`, a saturating starvation counter that outputs `force_if`.
- Everything else is flat inside `mem_arbiter`.

## Test plan
- IF only: `if_req` = 1, `if_addr` = 0x10, `mem_gnt` = 1, `mem_rvalid` = 1 with 0x00500093 in cycle 2 → `mem_addr` = 0x10 in cycle 1; `if_valid` = 1 and `if_rdata` = 0x00500093 in cycle 2; `if_stall` = 1 in cycles 0–1.
- Simultaneous requests: `dm_req` (load, 0x100) and `if_req` (0x4) in cycle 0 → `mem_addr` = 0x100 in cycle 1, `dm_valid` in cycle 2; `mem_addr` = 0x4 in cycle 4, `if_valid` in cycle 5; `if_stall` held throughout.
- Store: `dm_we` = 1, `dm_be` = 4'b0011, `dm_addr` = 0x8, `dm_wdata` = 0xDEADBEEF → REQ shows `mem_we` = 1, `mem_be` = 0011, `mem_wdata` = 0xDEADBEEF; `dm_valid` pulses on the ack.
- Starvation, `STARVE_MAX` = 2: `dm_req` and `if_req` held high continuously → grant order DM, DM, IF, DM, DM, IF.
- Grant backpressure: `mem_gnt` = 0 for 3 cycles in REQ → `mem_req` and all fields stable; state remains REQ; no `*_valid`.
- Reset in RESP: `rst` = 0 for one cycle, then `mem_rvalid` = 1 → state IDLE, `mem_req` = 0, no `if_valid`/`dm_valid` pulse, `starve_cnt` = 0.
